// File: rtl/arm_pkg.sv
// ARM-subset constants, control bundle and decode helpers.
// Shared by the decode stage and its register file.
package arm_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(
    input logic [31:0] instr
  );
    ctrl_t c;
    c = '0;
    unique case (instr[27:26])
      MODE_DP: begin
        c.s = instr[20];
        case (instr[24:21])
          OP_MOV: c.exe_cmd = CMD_MOV;
          OP_MVN: c.exe_cmd = CMD_MVN;
          OP_ADD: c.exe_cmd = CMD_ADD;
          OP_ADC: c.exe_cmd = CMD_ADC;
          OP_SUB: c.exe_cmd = CMD_SUB;
          OP_SBC: c.exe_cmd = CMD_SBC;
          OP_AND: c.exe_cmd = CMD_AND;
          OP_ORR: c.exe_cmd = CMD_ORR;
          OP_EOR: c.exe_cmd = CMD_EOR;
          OP_CMP: c.exe_cmd = CMD_SUB;
          OP_TST: c.exe_cmd = CMD_AND;
          default: c.exe_cmd = CMD_NOP;
        endcase
        // compares only set flags
        c.wb_en = (c.exe_cmd != CMD_NOP) &&
                  (instr[24:21] != OP_CMP) &&
                  (instr[24:21] != OP_TST);
      end
      MODE_MEM: begin
        c.exe_cmd  = CMD_ADD;
        c.mem_r_en = instr[20];
        c.wb_en    = instr[20];
        c.mem_w_en = !instr[20];
      end
      MODE_BR: c.b = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic cond_pass(
    input logic [3:0] cond,
    input logic [3:0] sr
  );
    logic n, z, c, v, p;
    n = sr[SR_N];
    z = sr[SR_Z];
    c = sr[SR_C];
    v = sr[SR_V];
    case (cond)
      COND_EQ: p = z;
      COND_NE: p = !z;
      COND_CS: p = c;
      COND_CC: p = !c;
      COND_MI: p = n;
      COND_PL: p = !n;
      COND_VS: p = v;
      COND_VC: p = !v;
      COND_HI: p = c && !z;
      COND_LS: p = !c || z;
      COND_GE: p = (n == v);
      COND_LT: p = (n != v);
      COND_GT: p = !z && (n == v);
      COND_LE: p = z || (n != v);
      COND_AL: p = 1'b1;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/reg_file_bp.sv
// GPR file: sync write, async read, sync reset pattern.
// ID_WB_BYPASS_EN makes reads write-first for wb_dest.
module reg_file_bp
  import arm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int NUM_REGS    = 15,
  parameter int RF_INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam logic [REG_AW:0] NR =
    (REG_AW+1)'(NUM_REGS);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  logic w_ok, r1_ok, r2_ok;

  always_comb begin
    w_ok  = {1'b0, waddr}  < NR;
    r1_ok = {1'b0, raddr1} < NR;
    r2_ok = {1'b0, raddr2} < NR;
    mem_d = mem_q;
    if (we && w_ok) mem_d[waddr] = wdata;
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (r1_ok) rdata1 = mem_q[raddr1];
    if (r2_ok) rdata2 = mem_q[raddr2];
`ifdef ID_WB_BYPASS_EN
    if (we && w_ok && raddr1 == waddr)
      rdata1 = wdata;
    if (we && w_ok && raddr2 == waddr)
      rdata2 = wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= (RF_INIT_IDX != 0) ?
                    DATA_W'(i) : '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: RF read, cond check, RAW hazard, ID/EX reg.
// Macro ID_WB_BYPASS_EN: write-first RF, no wb hazard term.
module id_stage_pipe
  import arm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 4,
  parameter int NUM_REGS    = 15,
  parameter int RF_INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              in_valid,
  input  logic              freeze,
  input  logic              flush,
  input  logic [3:0]        sr,
  input  logic              wb_en_in,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              ex_wb_en,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              hazard_stall,
  output logic              id_valid,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm_24,
  output logic [REG_AW-1:0] dest,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic              use_src1,
  output logic              use_src2,
  output logic [DATA_W-1:0] pc_out
);

  typedef struct packed {
    logic              id_valid;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [REG_AW-1:0] dest;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic              use_src1;
    logic              use_src2;
    logic [DATA_W-1:0] pc;
  } id_ex_t;

  id_ex_t id_ex_q, id_ex_d;
  id_ex_t dec_c, bub_c;

  ctrl_t             ctrl_c;
  logic [1:0]        mode_c;
  logic              cond_ok;
  logic              is_str, is_mov;
  logic [REG_AW-1:0] src1_c, src2_c;
  logic              use1_c, use2_c;
  logic              hit1, hit2;
  logic [DATA_W-1:0] rn_c, rm_c;

  reg_file_bp #(
    .DATA_W      (DATA_W),
    .REG_AW      (REG_AW),
    .NUM_REGS    (NUM_REGS),
    .RF_INIT_IDX (RF_INIT_IDX)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_en_in),
    .waddr  (wb_dest),
    .wdata  (wb_value),
    .raddr1 (src1_c),
    .raddr2 (src2_c),
    .rdata1 (rn_c),
    .rdata2 (rm_c)
  );

  always_comb begin
    mode_c  = instr_in[27:26];
    ctrl_c  = decode_ctrl(instr_in);
    cond_ok = cond_pass(instr_in[31:28], sr);
    is_str  = (mode_c == MODE_MEM) && !instr_in[20];
    is_mov  = (mode_c == MODE_DP) &&
              ((instr_in[24:21] == OP_MOV) ||
               (instr_in[24:21] == OP_MVN));
    src1_c  = REG_AW'(instr_in[19:16]);
    src2_c  = is_str ? REG_AW'(instr_in[15:12])
                     : REG_AW'(instr_in[3:0]);
    use1_c  = !(is_mov || (mode_c == MODE_BR));
    use2_c  = ((mode_c == MODE_DP) && !instr_in[25])
              || is_str;
  end

  always_comb begin
    hit1 = (ex_wb_en  && src1_c == ex_dest) ||
           (mem_wb_en && src1_c == mem_dest);
    hit2 = (ex_wb_en  && src2_c == ex_dest) ||
           (mem_wb_en && src2_c == mem_dest);
`ifndef ID_WB_BYPASS_EN
    // pre-write read: the wb value is not yet visible
    hit1 = hit1 || (wb_en_in && src1_c == wb_dest);
    hit2 = hit2 || (wb_en_in && src2_c == wb_dest);
`endif
    hazard_stall = in_valid &&
                   ((use1_c && hit1) || (use2_c && hit2));
  end

  always_comb begin
    dec_c               = '0;
    dec_c.id_valid      = 1'b1;
    dec_c.ctrl          = ctrl_c;
    dec_c.val_rn        = rn_c;
    dec_c.val_rm        = rm_c;
    dec_c.imm           = instr_in[25];
    dec_c.shift_operand = instr_in[11:0];
    dec_c.signed_imm_24 = instr_in[23:0];
    dec_c.dest          = REG_AW'(instr_in[15:12]);
    dec_c.src1          = src1_c;
    dec_c.src2          = src2_c;
    dec_c.use_src1      = use1_c;
    dec_c.use_src2      = use2_c;
    dec_c.pc            = pc_in;

    // bubble keeps the datapath fields, kills controls
    bub_c          = dec_c;
    bub_c.id_valid = 1'b0;
    bub_c.ctrl     = '0;

    id_ex_d = id_ex_q;
    if (flush)
      id_ex_d = bub_c;
    else if (freeze)
      id_ex_d = id_ex_q;
    else if (!in_valid || hazard_stall || !cond_ok)
      id_ex_d = bub_c;
    else
      id_ex_d = dec_c;
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign id_valid      = id_ex_q.id_valid;
  assign wb_en         = id_ex_q.ctrl.wb_en;
  assign mem_r_en      = id_ex_q.ctrl.mem_r_en;
  assign mem_w_en      = id_ex_q.ctrl.mem_w_en;
  assign b             = id_ex_q.ctrl.b;
  assign s             = id_ex_q.ctrl.s;
  assign exe_cmd       = id_ex_q.ctrl.exe_cmd;
  assign val_rn        = id_ex_q.val_rn;
  assign val_rm        = id_ex_q.val_rm;
  assign imm           = id_ex_q.imm;
  assign shift_operand = id_ex_q.shift_operand;
  assign signed_imm_24 = id_ex_q.signed_imm_24;
  assign dest          = id_ex_q.dest;
  assign src1          = id_ex_q.src1;
  assign src2          = id_ex_q.src2;
  assign use_src1      = id_ex_q.use_src1;
  assign use_src2      = id_ex_q.use_src2;
  assign pc_out        = id_ex_q.pc;

endmodule
